// File: rtl/aes_dec_pkg.sv
// Shared types and tables for the sequential AES-128 inverse-cipher controller.
// Holds the FSM encoding, the round count, the forward S-box and the Rcon table.
package aes_dec_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        KEYEXP = 3'd1,
        ADDKEY = 3'd2,
        ROUND  = 3'd3,
        DONE   = 3'd4
    } state_e;

    localparam int NR = 10;

    // Byte b of the S-box sits at bits [8b:8b+7].
    localparam logic [0:2047] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TBL[8*b +: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/aes_key_step.sv
// One AES-128 key-schedule step: next round key from the previous one and its Rcon.
// Purely combinational; the controller registers the result into its round-key file.
module aes_key_step
    import aes_dec_pkg::*;
(
    input  logic [0:127] i_rk_prev,
    input  logic [7:0]   i_rcon,
    output logic [0:127] o_rk_next
);

    logic [0:31] w_w0, w_w1, w_w2, w_w3;
    logic [0:31] w_rot, w_temp;
    logic [0:31] w_n0, w_n1, w_n2, w_n3;

    assign w_w0 = i_rk_prev[0:31];
    assign w_w1 = i_rk_prev[32:63];
    assign w_w2 = i_rk_prev[64:95];
    assign w_w3 = i_rk_prev[96:127];

    assign w_rot  = {w_w3[8:31], w_w3[0:7]};
    assign w_temp = {sbox(w_rot[0:7]), sbox(w_rot[8:15]), sbox(w_rot[16:23]), sbox(w_rot[24:31])}
                    ^ {i_rcon, 24'h000000};

    assign w_n0 = w_w0 ^ w_temp;
    assign w_n1 = w_w1 ^ w_n0;
    assign w_n2 = w_w2 ^ w_n1;
    assign w_n3 = w_w3 ^ w_n2;

    assign o_rk_next = {w_n0, w_n1, w_n2, w_n3};

endmodule

// File: rtl/aes_decrypt_seq.sv
// Sequential AES-128 decrypt controller: expands (or reuses) the key schedule, then
// steps an external inverse-round datapath through NR rounds and hands back the plaintext.
module aes_decrypt_seq
    import aes_dec_pkg::*;
#(
    parameter int KEY_CACHE = 1,
    parameter int NR        = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [0:127] encr_data,
    input  logic [0:127] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:127] decryp_data,
    output logic         busy,
    output logic [0:127] rnd_in,
    output logic [0:127] rnd_key,
    output logic         rnd_final,
    input  logic [0:127] rnd_out
);

    state_e       r_state, w_next;
    logic [3:0]   r_cnt;
    logic [0:127] r_st;
    logic [0:127] r_rk [0:NR];
    logic [0:127] r_ckey;
    logic         r_cvalid;

    logic         w_accept, w_hit, w_exp_last;
    logic [7:0]   w_rcon;
    logic [0:127] w_rk_prev, w_rk_next, w_rk_cur;

    assign w_accept   = in_valid && (r_state == IDLE);
    assign w_hit      = (KEY_CACHE != 0) && r_cvalid && (key == r_ckey);
    assign w_exp_last = (r_cnt == 4'(NR));
    assign w_rcon     = rcon(r_cnt);

    // During KEYEXP r_cnt is the round key being produced; in ROUND it is the key being used.
    always_comb begin
        w_rk_prev = r_rk[0];
        for (int i = 1; i <= NR; i++)
            if (r_cnt == 4'(i)) w_rk_prev = r_rk[i-1];
    end

    always_comb begin
        w_rk_cur = r_rk[0];
        for (int i = 1; i < NR; i++)
            if (r_cnt == 4'(i)) w_rk_cur = r_rk[i];
    end

    aes_key_step u_key_step (
        .i_rk_prev (w_rk_prev),
        .i_rcon    (w_rcon),
        .o_rk_next (w_rk_next)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = w_hit ? ADDKEY : KEYEXP;
            KEYEXP:  if (w_exp_last) w_next = ADDKEY;
            ADDKEY:  w_next = ROUND;
            ROUND:   if (r_cnt == 4'd0) w_next = DONE;
            DONE:    if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_st     <= '0;
            r_cnt    <= '0;
            r_ckey   <= '0;
            r_cvalid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (w_accept) begin
                    r_st  <= encr_data;
                    r_cnt <= 4'd1;
                end
                KEYEXP: begin
                    r_cnt <= r_cnt + 4'd1;
                    if (w_exp_last) begin
                        r_ckey   <= r_rk[0];
                        r_cvalid <= 1'b1;
                    end
                end
                ADDKEY: begin
                    r_st  <= r_st ^ r_rk[NR];
                    r_cnt <= 4'(NR - 1);
                end
                ROUND: begin
                    r_st <= rnd_out;
                    if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
                end
                default: ;
            endcase
        end
    end

    // Round-key file carries no reset; a hit leaves it untouched so the cached schedule survives.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (w_accept && !w_hit) r_rk[0] <= key;
            if (r_state == KEYEXP)
                for (int i = 1; i <= NR; i++)
                    if (r_cnt == 4'(i)) r_rk[i] <= w_rk_next;
        end
    end

    always_comb begin
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        decryp_data = '0;
        rnd_in      = '0;
        rnd_key     = '0;
        rnd_final   = 1'b0;
        case (r_state)
            IDLE:   in_ready = 1'b1;
            KEYEXP,
            ADDKEY: busy = 1'b1;
            ROUND: begin
                busy      = 1'b1;
                rnd_in    = r_st;
                rnd_key   = w_rk_cur;
                rnd_final = (r_cnt == 4'd0);
            end
            DONE: begin
                out_valid   = 1'b1;
                decryp_data = r_st;
            end
            default: ;
        endcase
    end

endmodule
